// File: rtl/ps2_scancode_ctrl.sv
// PS/2 scan-code sequencer: folds 0xE0/0xF0 prefix bytes into key events and
// queues them in a small first-word-fall-through FIFO with a ready/valid head.
module ps2_scancode_ctrl #(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] RX_DATA,
    input  logic       RX_VALID,
    input  logic       RX_ERR,
    output logic [7:0] EV_CODE,
    output logic       EV_EXT,
    output logic       EV_BREAK,
    output logic       EV_VALID,
    input  logic       EV_READY,
    output logic [7:0] LAST_CODE,
    output logic       OVERFLOW,
    output logic [7:0] ERR_CNT
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;
    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } event_t;

    state_t        state;
    logic [TW-1:0] tmo_cnt;
    event_t        mem [FIFO_DEPTH];
    logic [PW:0]   wr_ptr;
    logic [PW:0]   rd_ptr;

    logic          byte_ok;
    logic          is_prefix;
    logic          emit;
    logic          fifo_full;
    logic          pop;
    logic          push;
    logic [PW-1:0] rd_idx;
    logic [PW-1:0] prev_idx;
    event_t        new_ev;
    event_t        head;

    // NOTE: every signal assigned here gets a value on every path, so no latches are inferred.
    always_comb begin
        byte_ok     = RX_VALID & ~RX_ERR;
        is_prefix   = (RX_DATA == 8'hE0) || (RX_DATA == 8'hF0);
        emit        = byte_ok & ~is_prefix;
        new_ev.code = RX_DATA;
        new_ev.ext  = (state == EXT) || (state == EXT_BRK);
        new_ev.brk  = (state == BRK) || (state == EXT_BRK);
        EV_VALID    = (wr_ptr != rd_ptr);
        fifo_full   = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
        pop         = EV_VALID & EV_READY;
        push        = emit & (~fifo_full | pop);
        rd_idx      = rd_ptr[PW-1:0];
        prev_idx    = rd_idx - PW'(1);
        // While empty, the slot just behind the read pointer is the last entry consumed.
        head        = EV_VALID ? mem[rd_idx] : mem[prev_idx];
        EV_CODE     = head.code;
        EV_EXT      = head.ext;
        EV_BREAK    = head.brk;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            tmo_cnt <= '0;
        end else if (RX_VALID) begin
            tmo_cnt <= '0;
            if (RX_ERR) begin
                state <= IDLE;
            end else if (RX_DATA == 8'hE0) begin
                state <= EXT;
            end else if (RX_DATA == 8'hF0) begin
                state <= ((state == EXT) || (state == EXT_BRK)) ? EXT_BRK : BRK;
            end else begin
                state <= IDLE;
            end
        end else if (state == IDLE) begin
            tmo_cnt <= '0;
        end else if (tmo_cnt == TMO_LAST) begin
            state   <= IDLE;
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end

    // NOTE: the FIFO storage is reset because the empty-FIFO head view must read 0 after reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            OVERFLOW  <= 1'b0;
            LAST_CODE <= '0;
            ERR_CNT   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr[PW-1:0]] <= new_ev;
                wr_ptr              <= wr_ptr + (PW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (PW+1)'(1);
            end
            if (emit && fifo_full && !pop) begin
                OVERFLOW <= 1'b1;
            end
            if (emit && !new_ev.brk) begin
                LAST_CODE <= RX_DATA;
            end
            if (RX_VALID && RX_ERR && (ERR_CNT != 8'hFF)) begin
                ERR_CNT <= ERR_CNT + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_ps2_scancode_ctrl.sv
// Self-checking bench for ps2_scancode_ctrl: directed scenarios with literal
// expectations, then random traffic compared every cycle against an event-level model.
module tb_ps2_scancode_ctrl;
    localparam int T     = 12;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } ev_t;

    logic       CLK;
    logic       RST;
    logic [7:0] RX_DATA;
    logic       RX_VALID;
    logic       RX_ERR;
    logic [7:0] EV_CODE;
    logic       EV_EXT;
    logic       EV_BREAK;
    logic       EV_VALID;
    logic       EV_READY;
    logic [7:0] LAST_CODE;
    logic       OVERFLOW;
    logic [7:0] ERR_CNT;

    int n_checks = 0;
    int n_err    = 0;

    ps2_scancode_ctrl #(.TIMEOUT_CYCLES(T), .FIFO_DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_ERR(RX_ERR),
        .EV_CODE(EV_CODE), .EV_EXT(EV_EXT), .EV_BREAK(EV_BREAK), .EV_VALID(EV_VALID),
        .EV_READY(EV_READY), .LAST_CODE(LAST_CODE), .OVERFLOW(OVERFLOW), .ERR_CNT(ERR_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Event-level reference: pending-prefix flags, a queue of events, and the
    // time of the last received byte for the abandonment rule.
    ev_t  q[$];
    ev_t  last_read;
    logic p_ext, p_brk;
    logic [7:0] m_last, m_err;
    logic m_ovf;
    int   cyc, last_rx;

    initial begin
        forever begin
            @(posedge CLK or posedge RST);
            if (RST === 1'b1) begin
                q.delete();
                last_read = '0;
                p_ext = 1'b0; p_brk = 1'b0;
                m_last = '0; m_err = '0; m_ovf = 1'b0;
                cyc = 0; last_rx = 0;
            end else begin
                logic pop, do_emit;
                ev_t  ev;
                cyc++;
                pop     = (q.size() != 0) && (EV_READY === 1'b1);
                do_emit = 1'b0;
                ev      = '0;
                if (RX_VALID === 1'b1) begin
                    if ((p_ext || p_brk) && (cyc - last_rx > T)) begin
                        p_ext = 1'b0; p_brk = 1'b0;
                    end
                    last_rx = cyc;
                    if (RX_ERR === 1'b1) begin
                        if (m_err != 8'hFF) m_err = m_err + 8'd1;
                        p_ext = 1'b0; p_brk = 1'b0;
                    end else if (RX_DATA == 8'hE0) begin
                        p_ext = 1'b1; p_brk = 1'b0;
                    end else if (RX_DATA == 8'hF0) begin
                        p_brk = 1'b1;
                    end else begin
                        ev      = '{code: RX_DATA, ext: p_ext, brk: p_brk};
                        do_emit = 1'b1;
                        p_ext = 1'b0; p_brk = 1'b0;
                    end
                end
                if (pop) last_read = q.pop_front();
                if (do_emit) begin
                    if (!ev.brk) m_last = ev.code;
                    if (q.size() < DEPTH) q.push_back(ev);
                    else m_ovf = 1'b1;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge CLK);
            if (RST === 1'b0) begin
                ev_t h;
                h = (q.size() != 0) ? q[0] : last_read;
                check("cmp_valid", 32'(EV_VALID), 32'(q.size() != 0));
                check("cmp_code", 32'(EV_CODE), 32'(h.code));
                check("cmp_ext", 32'(EV_EXT), 32'(h.ext));
                check("cmp_break", 32'(EV_BREAK), 32'(h.brk));
                check("cmp_last", 32'(LAST_CODE), 32'(m_last));
                check("cmp_ovf", 32'(OVERFLOW), 32'(m_ovf));
                check("cmp_errcnt", 32'(ERR_CNT), 32'(m_err));
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic e = 1'b0);
        RX_DATA = d; RX_ERR = e; RX_VALID = 1'b1;
        @(negedge CLK);
        RX_VALID = 1'b0; RX_ERR = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    initial begin
        logic [7:0] seq[4];
        RX_DATA = '0; RX_VALID = 1'b0; RX_ERR = 1'b0; EV_READY = 1'b0; RST = 1'b0;
        #1 RST = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        check("rst_valid", 32'(EV_VALID), 0);
        check("rst_code", 32'(EV_CODE), 0);
        check("rst_last", 32'(LAST_CODE), 0);
        check("rst_ovf", 32'(OVERFLOW), 0);
        check("rst_err", 32'(ERR_CNT), 0);

        // Plain make, break, extended make, extended break.
        EV_READY = 1'b1;
        send(8'h1C);
        check("make_valid", 32'(EV_VALID), 1);
        check("make_code", 32'(EV_CODE), 32'h1C);
        check("make_flags", {EV_EXT, EV_BREAK}, 0);
        check("make_last", 32'(LAST_CODE), 32'h1C);
        send(8'hF0); send(8'h1C);
        check("brk_code", 32'(EV_CODE), 32'h1C);
        check("brk_flags", {EV_EXT, EV_BREAK}, 2'b01);
        check("brk_last", 32'(LAST_CODE), 32'h1C);
        send(8'hE0); send(8'h75);
        check("ext_code", 32'(EV_CODE), 32'h75);
        check("ext_flags", {EV_EXT, EV_BREAK}, 2'b10);
        check("ext_last", 32'(LAST_CODE), 32'h75);
        send(8'hE0); send(8'hF0); send(8'h75);
        check("extbrk_flags", {EV_EXT, EV_BREAK}, 2'b11);
        idle(1);

        // Overflow with a stalled consumer, then drain.
        EV_READY = 1'b0;
        for (int i = 0; i < 5; i++) send(8'h15 + 8'(i));
        check("ovf_set", 32'(OVERFLOW), 1);
        check("ovf_last", 32'(LAST_CODE), 32'h19);
        EV_READY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_code", 32'(EV_CODE), 32'h15 + i);
            @(negedge CLK);
        end
        check("drain_empty", 32'(EV_VALID), 0);
        check("drain_hold", 32'(EV_CODE), 32'h18);

        // Full FIFO with simultaneous pop and push.
        do_reset();
        EV_READY = 1'b0;
        for (int i = 0; i < 4; i++) send(8'h31 + 8'(i));
        EV_READY = 1'b1;
        send(8'h2A);
        EV_READY = 1'b0;
        check("popush_ovf", 32'(OVERFLOW), 0);
        check("popush_head", 32'(EV_CODE), 32'h32);
        seq = '{8'h32, 8'h33, 8'h34, 8'h2A};
        EV_READY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("popush_order", 32'(EV_CODE), 32'(seq[i]));
            @(negedge CLK);
        end
        check("popush_empty", 32'(EV_VALID), 0);

        // Prefix abandonment at and just before the timeout boundary.
        send(8'hE0); idle(T); send(8'h1C);
        check("tmo_fired", {EV_EXT, EV_BREAK}, 0);
        idle(1);
        send(8'hE0); idle(T - 1); send(8'h1C);
        check("tmo_edge", {EV_EXT, EV_BREAK}, 2'b10);
        idle(1);

        // Frame error cancels a pending break.
        send(8'hF0); send(8'h55, 1'b1); send(8'h1C);
        check("err_flags", {EV_EXT, EV_BREAK}, 0);
        check("err_code", 32'(EV_CODE), 32'h1C);
        check("err_cnt1", 32'(ERR_CNT), 1);
        idle(1);
        for (int i = 0; i < 300; i++) send(8'($urandom_range(0, 255)), 1'b1);
        check("err_sat", 32'(ERR_CNT), 255);

        // Asynchronous reset mid-sequence with events pending.
        EV_READY = 1'b0;
        send(8'h41); send(8'h42); send(8'hE0);
        check("pre_rst_valid", 32'(EV_VALID), 1);
        check("pre_rst_last", 32'(LAST_CODE), 32'h42);
        #2 RST = 1'b1;
        #1;
        check("arst_valid", 32'(EV_VALID), 0);
        check("arst_code", {EV_CODE, EV_EXT, EV_BREAK}, 0);
        check("arst_last", 32'(LAST_CODE), 0);
        check("arst_err", 32'(ERR_CNT), 0);
        @(negedge CLK);
        RST = 1'b0;
        EV_READY = 1'b1;
        send(8'h1C);
        check("post_rst_valid", 32'(EV_VALID), 1);
        check("post_rst_ev", {EV_CODE, EV_EXT, EV_BREAK}, {8'h1C, 2'b00});

        // Random traffic checked by the per-cycle compare process.
        for (int n = 0; n < 3000; n++) begin
            int r;
            EV_READY = ($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 24) == 0) begin
                RX_VALID = 1'b0;
                idle(T - 1 + $urandom_range(0, 2));
            end else begin
                r        = $urandom_range(0, 99);
                RX_DATA  = (r < 20) ? 8'hE0 : (r < 40) ? 8'hF0 : 8'($urandom_range(0, 255));
                RX_ERR   = ($urandom_range(0, 9) == 0);
                RX_VALID = ($urandom_range(0, 9) < 7);
                @(negedge CLK);
            end
        end
        RX_VALID = 1'b0; RX_ERR = 1'b0; EV_READY = 1'b1;
        idle(DEPTH + 2);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/ps2_scancode_ctrl.md
# ps2_scancode_ctrl

Scan-code sequencer between the PS/2 frame receiver and the keyboard consumers (LED, 7-segment display logic). It takes the receiver's validated bytes and tracks the 0xE0 (extended) and 0xF0 (break) prefix sequences. Each complete sequence becomes one key event {code, extended, break}, which is pushed into a small first-word-fall-through FIFO with a ready/valid output. It also keeps the last make code for display and counts frame errors.

## Interface

- TIMEOUT_CYCLES, 100000: CLK cycles without a byte after which a partial prefix sequence is abandoned.
- FIFO_DEPTH, 4: event FIFO entries; power of two, ≥2.

- CLK  in  1  system clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- RX_DATA  in  8  received byte from the PS/2 frame receiver.
- RX_VALID  in  1  one-cycle strobe; RX_DATA and RX_ERR are valid this cycle.
- RX_ERR  in  1  parity or stop-bit error on this frame; qualified by RX_VALID.
- EV_CODE  out  8  scan code of the FIFO head event.
- EV_EXT  out  1  head event was 0xE0-prefixed.
- EV_BREAK  out  1  head event is a key release.
- EV_VALID  out  1  FIFO not empty.
- EV_READY  in  1  consumer accepts the head when EV_VALID & EV_READY.
- LAST_CODE  out  8  code of the most recent emitted make event.
- OVERFLOW  out  1  sticky; set when an event is dropped because the FIFO is full.
- ERR_CNT  out  8  saturating count of RX_ERR frames.

## Operation

- All outputs reset to 0, asynchronously. This covers the FIFO storage, pointers, FSM state, the timeout counter and the sticky flags.
- FSM states: IDLE, EXT, BRK, EXT_BRK. Transitions happen only on RX_VALID & !RX_ERR.
  - IDLE: 0xE0 → EXT; 0xF0 → BRK; any other byte → emit {byte,0,0}, stay IDLE.
  - EXT: 0xF0 → EXT_BRK; 0xE0 → EXT; other → emit {byte,1,0} → IDLE.
  - BRK: 0xF0 → BRK; 0xE0 → EXT (the pending break is discarded); other → emit {byte,0,1} → IDLE.
  - EXT_BRK: 0xF0 → EXT_BRK; 0xE0 → EXT; other → emit {byte,1,1} → IDLE.
  - Bytes other than 0xE0/0xF0 (including 0xE1, 0xAA, 0xFA) are treated as ordinary codes.
- Frame error (RX_VALID & RX_ERR):
  - The byte is discarded and the state goes to IDLE; nothing is emitted.
  - ERR_CNT increments and saturates at 255.
- Timeout:
  - The counter is cleared on any RX_VALID or while the state is IDLE; otherwise it increments each cycle.
  - When it reaches TIMEOUT_CYCLES-1, the state goes to IDLE with no emit and the counter clears.
  - If RX_VALID arrives in the same cycle, the byte wins and is processed normally.
- LAST_CODE: loads the code on every emitted make event (break=0), whether or not the FIFO accepts the event.
- FIFO:
  - An emit writes at the tail. A pop occurs on EV_VALID & EV_READY.
  - Full and no pop in the same cycle: the event is dropped and OVERFLOW is set. OVERFLOW clears only on RST.
  - Full with a pop in the same cycle: the write is accepted and the count is unchanged.
  - Empty with an emit: the event appears at the head on the next cycle. There is no same-cycle bypass.
  - Pointers wrap modulo FIFO_DEPTH. An extra occupancy bit (or count) distinguishes full from empty.
  - EV_CODE/EV_EXT/EV_BREAK show the head entry whenever EV_VALID=1. When the FIFO is empty they hold the last read entry (0 after reset).
- EV_VALID never deasserts without a pop; the head is stable while EV_VALID & !EV_READY.

## Timing

- Latency: the final byte strobed at edge n gives EV_VALID=1 after edge n+1 (one cycle), provided the FIFO was empty.
- Prefix bytes produce no output activity.
- RX_VALID may be asserted on consecutive cycles; one byte is processed per cycle with no stall.
- The block has no back-pressure toward the receiver; loss is signalled only through OVERFLOW.
- A pop and an emit in the same cycle are both honoured.
- RST asserted mid-sequence or with events pending clears everything immediately. The first byte after release is interpreted from IDLE.
- ERR_CNT and OVERFLOW update one cycle after the causing strobe.

## Test plan

- Bytes 0x1C with EV_READY=1 → one event {0x1C,0,0}, EV_VALID high one cycle after the strobe; LAST_CODE=0x1C.
- 0xF0, 0x1C → {0x1C,0,1}; LAST_CODE unchanged. Then 0xE0, 0x75 → {0x75,1,0}. Then 0xE0, 0xF0, 0x75 → {0x75,1,1}.
- EV_READY=0, make codes 0x15,0x16,0x17,0x18,0x19 (depth 4) → OVERFLOW=1 after 0x19 and LAST_CODE=0x19. Raise EV_READY → pops 0x15..0x18 in order, then EV_VALID=0.
- FIFO full, then pop and a new make 0x2A in the same cycle → no overflow; 0x2A becomes the last entry.
- 0xE0, wait TIMEOUT_CYCLES idle cycles, then 0x1C → {0x1C,0,0}. Separately: 0xF0, then a byte with RX_ERR=1, then 0x1C → {0x1C,0,0} and ERR_CNT=1.
- Send 0xE0 with two events queued, assert RST asynchronously between edges → all outputs 0 immediately. After release, 0x1C gives {0x1C,0,0}.
